pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 106 ++++++++++
 tb/tb_pipelined_adder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented carry-chain adder/subtractor: one SEG-bit slice per pipeline stage,
// with a valid/ready handshake that stalls the whole pipe on output backpressure.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4   // WIDTH must be a multiple of STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG = WIDTH / STAGES;

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * SEG;
    localparam int unsigned REM = WIDTH - LO;

    logic             v_i;
    logic             c_i;
    logic [REM-1:0]   a_i;
    logic [REM-1:0]   b_i;
    logic [SEG:0]     seg_sum;
    logic [LO+SEG-1:0] res_d;

    assign seg_sum = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};

    // Subtraction is folded into stage 0 by inverting b and the carry-in once;
    // later stages only see the already-inverted operand slices.
    if (k == 0) begin : g_src
      assign v_i   = in_valid;
      assign c_i   = cin ^ sub;
      assign a_i   = a;
      assign b_i   = b ^ {WIDTH{sub}};
      assign res_d = seg_sum[SEG-1:0];
    end else begin : g_src
      assign v_i   = g_stage[k-1].g_mid.v_q;
      assign c_i   = g_stage[k-1].g_mid.c_q;
      assign a_i   = g_stage[k-1].g_mid.a_q;
      assign b_i   = g_stage[k-1].g_mid.b_q;
      assign res_d = {seg_sum[SEG-1:0], g_stage[k-1].g_mid.res_q};
    end

    if (k < STAGES - 1) begin : g_mid
      // Only the not-yet-added operand slices travel on; finished result slices accumulate.
      logic                v_q;
      logic                c_q;
      logic [LO+SEG-1:0]   res_q;
      logic [REM-SEG-1:0]  a_q;
      logic [REM-SEG-1:0]  b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          res_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
        end else if (advance) begin
          v_q   <= v_i;
          c_q   <= seg_sum[SEG];
          res_q <= res_d;
          a_q   <= a_i[REM-1:SEG];
          b_q   <= b_i[REM-1:SEG];
        end
      end
    end else begin : g_out
      logic msb_carry;

      // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
      assign msb_carry = a_i[SEG-1] ^ b_i[SEG-1] ^ seg_sum[SEG-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          out_valid <= v_i;
          sum       <= res_d;
          cout      <= seg_sum[SEG];
          ovf       <= seg_sum[SEG] ^ msb_carry;
          zero      <= (res_d == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 4-stage main instance with a scoreboard,
// plus 1-stage and 8-stage instances for latency at the extremes.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cin, sub;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;

  logic        v1, v8, ready_hi;
  logic        rdy1, vo1, c1, o1, z1;
  logic        rdy8, vo8, c8, o8, z8;
  logic [31:0] s1, s8;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(vo1), .out_ready(ready_hi), .sum(s1),
    .cout(c1), .ovf(o1), .zero(z1)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(vo8), .out_ready(ready_hi), .sum(s8),
    .cout(c8), .ovf(o8), .zero(z8)
  );

  // Reference: {zero, ovf, cout, sum}; overflow from operand/result sign agreement.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [31:0] yy;
    logic        cc;
    logic [32:0] r;
    logic        v;
    yy = s ? ~y : y;
    cc = s ? ~ci : ci;
    r  = {1'b0, x} + {1'b0, yy} + {32'd0, cc};
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {(r[31:0] == 32'd0), v, r[32], r[31:0]};
  endfunction

  task automatic test_reset;
    int stray;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; sub = 1'b0;
    v1 = 1'b1; v8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b z=%b, expected all 0",
               out_valid, sum, cout, ovf, zero);
    end
    checks++;
    if ({vo1, vo8} !== 2'b00) begin
      errors++;
      $display("FAIL reset_variants: got vo1=%b vo8=%b, expected 0 0", vo1, vo8);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; v1 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || vo1 !== 1'b0 || vo8 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_override: got %0d cycles with out_valid, expected 0", stray);
    end
  endtask

  task automatic test_latency;
    int n;
    logic found;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_in_ready: got %b, expected 1", in_ready);
    end
    n = 0; found = 1'b0;
    while (n < 20 && !found) begin
      @(posedge clk); n++;
      #1 in_valid = 1'b0;
      @(negedge clk);
      found = out_valid;
    end
    checks++;
    if (!found || n != 4) begin
      errors++;
      $display("FAIL latency_4: got %0d cycles (seen=%b), expected 4", n, found);
    end
    checks++;
    if ({zero, ovf, cout, sum} !== {1'b1, 1'b0, 1'b1, 32'h0000_0000}) begin
      errors++;
      $display("FAIL latency_result: got z=%b o=%b c=%b sum=%h, expected z=1 o=0 c=1 sum=00000000",
               zero, ovf, cout, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [31:0] da [7] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000,
                            32'h00FF_FFFF, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] db [7] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001,
                            32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    logic        dc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ds [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int total, idx, cyc;
    logic [34:0] exp;
    total = 7 + 24; idx = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (idx < 7) begin
        a = da[idx]; b = db[idx]; cin = dc[idx]; sub = ds[idx];
        in_valid = 1'b1; out_ready = 1'b1;
      end else begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid  = (idx < total) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL vec_extra: got sum=%h, expected no result", sum);
        end else begin
          exp = exp_q.pop_front();
          if ({zero, ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL vec_result: got z=%b o=%b c=%b sum=%h, expected z=%b o=%b c=%b sum=%h",
                     zero, ovf, cout, sum, exp[34], exp[33], exp[32], exp[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        idx++;
      end
      if (idx == total && exp_q.size() == 0) break;
    end
    checks++;
    if (idx != total || exp_q.size() != 0) begin
      errors++;
      $display("FAIL vec_drain: got %0d sent %0d pending, expected %0d sent 0 pending",
               idx, exp_q.size(), total);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    int sent, outs, stall, cyc;
    logic stalled;
    logic [34:0] exp;
    sent = 0; outs = 0; stall = 0; stalled = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (!stalled && out_valid) begin
        stalled = 1'b1;
        stall   = 3;
      end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      in_valid = (sent < 8);
      a = sent; b = 32'h10; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (!out_ready) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h10 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall_hold: got v=%b sum=%h in_ready=%b, expected v=1 sum=00000010 in_ready=0",
                   out_valid, sum, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got sum=%h, expected no result", sum);
        end else begin
          exp = exp_q.pop_front();
          outs++;
          if ({zero, ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL b2b_result: got sum=%h c=%b, expected sum=%h c=%b",
                     sum, cout, exp[31:0], exp[32]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      if (sent == 8 && exp_q.size() == 0) break;
    end
    checks++;
    if (outs != 8 || !stalled) begin
      errors++;
      $display("FAIL b2b_count: got %0d results (stall seen=%b), expected 8 with stall", outs, stalled);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_flush;
    int stray, acc;
    acc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (in_ready) acc++;
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'd0 || acc != 3) begin
      errors++;
      $display("FAIL flush_outputs: got v=%b sum=%h c=%b o=%b z=%b accepted=%0d, expected all 0 accepted=3",
               out_valid, sum, cout, ovf, zero, acc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready: got %b, expected 1", in_ready);
    end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL flush_stale: got %0d stale results, expected 0", stray);
    end
  endtask

  task automatic test_stages;
    int n, lat;
    logic found;
    logic [34:0] got;
    for (int cfg = 0; cfg < 2; cfg++) begin
      @(posedge clk); #1;
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
      if (cfg == 0) v1 = 1'b1; else v8 = 1'b1;
      lat = (cfg == 0) ? 1 : 8;
      n = 0; found = 1'b0;
      while (n < 20 && !found) begin
        @(posedge clk); n++;
        #1 v1 = 1'b0; v8 = 1'b0;
        @(negedge clk);
        found = (cfg == 0) ? vo1 : vo8;
      end
      checks++;
      if (!found || n != lat) begin
        errors++;
        $display("FAIL stages_latency: got %0d cycles (seen=%b), expected %0d", n, found, lat);
      end
      got = (cfg == 0) ? {z1, o1, c1, s1} : {z8, o8, c8, s8};
      checks++;
      if (got !== {1'b1, 1'b0, 1'b1, 32'h0000_0000}) begin
        errors++;
        $display("FAIL stages_result: got z=%b o=%b c=%b sum=%h, expected z=1 o=0 c=1 sum=00000000 (latency %0d)",
                 got[34], got[33], got[32], got[31:0], lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v1 = 1'b0; v8 = 1'b0; ready_hi = 1'b1;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    test_stages();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
